pwm_capture: RTL and testbench

//  Receive-side PWM measurement block: samples an asynchronous PWM waveform and reports
//  the high time (DUTY) and full period (PERIOD) of each complete cycle, in CLK cycles.
//  It is the consumer end of the counter-driven PWM generator path (4-bit counter + compare).
//  It closes the loop for on-board self-check and for decoding external PWM inputs.

---
 rtl/pwm_capture_pkg.sv | 14 +
 rtl/pwm_capture_edge_sync.sv | 69 ++++++
 rtl/pwm_capture.sv | 128 ++++++++++++
 tb/tb_pwm_capture.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture path: FSM state encodings and default widths,
// kept in one place so generator and capture agree on counter sizes.
package pwm_capture_pkg;

  localparam int CW_DEFAULT       = 8;
  localparam int FILT_LEN_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// Edge front end for pwm_capture: 2-FF synchronizer, optional glitch filter
// (PWM_CAP_FILTER_EN), one-cycle delayed copy and rise/fall strobes.
module pwm_capture_edge_sync
  import pwm_capture_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;
  logic f;

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("pwm_capture_edge_sync: FILT_LEN must be at least 1");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FCW-1:0] FILT_TC = FCW'(FILT_LEN - 1);

  logic [FCW-1:0] filt_cnt;

  // f follows s2 only once s2 has disagreed for FILT_LEN cycles in a row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f        <= 1'b0;
      filt_cnt <= '0;
    end else if (s2 == f) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_TC) begin
      f        <= s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FCW'(1);
    end
  end
`else
  assign f = s2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3 <= 1'b0;
    end else begin
      s3 <= f;
    end
  end

  assign rise = f & ~s3;
  assign fall = ~f & s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rise-to-rise period of each complete cycle in clk cycles.
// Optional input glitch filter is enabled with PWM_CAP_FILTER_EN.
//
// state | meaning
// IDLE  | disarmed; waiting for the first rise (also after EN=0 or saturation)
// HIGH  | input high; per_cnt counts the high phase
// LOW   | input low; per_cnt keeps counting until the closing rise
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CW       = CW_DEFAULT,
  parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pwm_in,
  output logic [CW-1:0] duty,
  output logic [CW-1:0] period,
  output logic          valid,
  output logic          ovf,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  cap_state_e    state;
  cap_state_e    state_n;
  logic [CW-1:0] per_cnt;
  logic [CW-1:0] per_cnt_n;
  logic [CW-1:0] hi_lat;
  logic [CW-1:0] hi_lat_n;
  logic [CW-1:0] duty_n;
  logic [CW-1:0] period_n;
  logic          valid_n;
  logic          ovf_n;
  logic          rise;
  logic          fall;

  pwm_capture_edge_sync #(
    .FILT_LEN(FILT_LEN)
  ) u_edge_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      per_cnt <= '0;
      hi_lat  <= '0;
      duty    <= '0;
      period  <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      per_cnt <= per_cnt_n;
      hi_lat  <= hi_lat_n;
      duty    <= duty_n;
      period  <= period_n;
      valid   <= valid_n;
      ovf     <= ovf_n;
    end
  end

  always_comb begin
    state_n   = state;
    per_cnt_n = per_cnt;
    hi_lat_n  = hi_lat;
    duty_n    = duty;
    period_n  = period;
    valid_n   = 1'b0;
    ovf_n     = 1'b0;
    if (!en) begin
      state_n   = IDLE;
      per_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_n   = HIGH;
            per_cnt_n = CW'(1);
          end
        end
        HIGH: begin
          // a high phase reaching CNT_MAX cannot belong to a measurable period
          if (per_cnt == CNT_MAX) begin
            ovf_n     = 1'b1;
            state_n   = IDLE;
            per_cnt_n = '0;
          end else if (fall) begin
            hi_lat_n  = per_cnt;
            state_n   = LOW;
            per_cnt_n = per_cnt + CW'(1);
          end else begin
            per_cnt_n = per_cnt + CW'(1);
          end
        end
        LOW: begin
          if (rise) begin
            duty_n    = hi_lat;
            period_n  = per_cnt;
            valid_n   = 1'b1;
            state_n   = HIGH;
            per_cnt_n = CW'(1);
          end else if (per_cnt == CNT_MAX) begin
            ovf_n     = 1'b1;
            state_n   = IDLE;
            per_cnt_n = '0;
          end else begin
            per_cnt_n = per_cnt + CW'(1);
          end
        end
        default: begin
          state_n   = IDLE;
          per_cnt_n = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: directed PWM waveforms push expected VALID/OVF
// events with their arrival cycle; a negedge monitor pops and compares them.
module tb_pwm_capture;

`ifdef PWM_CAP_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pwm_in;
  logic [7:0] duty;
  logic [7:0] period;
  logic       valid;
  logic       ovf;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit is_ovf;
    int duty;
    int period;
    int at;
  } exp_t;

  exp_t q[$];
  exp_t e;

  pwm_capture dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pwm_in(pwm_in),
    .duty  (duty),
    .period(period),
    .valid (valid),
    .ovf   (ovf),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_valid(input int d, input int p);
    exp_t x;
    x.is_ovf = 1'b0;
    x.duty   = d;
    x.period = p;
    x.at     = cyc + LAT;
    q.push_back(x);
  endtask

  task automatic push_ovf(input int d, input int p);
    exp_t x;
    x.is_ovf = 1'b1;
    x.duty   = d;
    x.period = p;
    x.at     = cyc + LAT + 255;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (valid || ovf) begin
      if (valid && ovf) begin
        checks++;
        errors++;
        $display("FAIL valid_ovf_overlap at cycle %0d", cyc);
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event valid=%0d ovf=%0d duty=%0d period=%0d cycle=%0d required none",
                 valid, ovf, duty, period, cyc);
      end else begin
        e = q.pop_front();
        checks++;
        if (valid != !e.is_ovf || ovf != e.is_ovf || int'(duty) != e.duty || int'(period) != e.period) begin
          errors++;
          $display("FAIL scoreboard_data actual valid=%0d ovf=%0d duty=%0d period=%0d required valid=%0d ovf=%0d duty=%0d period=%0d",
                   valid, ovf, duty, period, !e.is_ovf, e.is_ovf, e.duty, e.period);
        end
        checks++;
        if (cyc != e.at) begin
          errors++;
          $display("FAIL scoreboard_latency actual cycle=%0d required cycle=%0d", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [3:0] c4;
    rst    = 1'b1;
    en     = 1'b0;
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset_duty", duty, 0);
    chk("reset_period", period, 0);
    chk("reset_valid", valid, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;

    // H=5 / L=11 stream; first rise only arms
    en = 1'b1;
    drive(1'b0, 4);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) push_valid(5, 16);
      drive(1'b1, 5);
      drive(1'b0, 11);
    end
    push_valid(5, 16);
    drive(1'b1, 5);
    drive(1'b0, 4);
    chk("t1_busy", busy, 1);
    en = 1'b0;
    drive(1'b0, 3);
    chk("t1_busy_after_en0", busy, 0);
    chk("t1_duty_hold", duty, 5);
    chk("t1_period_hold", period, 16);

    // 4-bit counter compare OUT<6
    en = 1'b1;
    drive(1'b0, 3);
    c4 = 4'd0;
    for (int i = 0; i < 96; i++) begin
      if (c4 == 4'd0 && i != 0) push_valid(6, 16);
      pwm_in = (c4 < 4'd6);
      c4 = c4 + 4'd1;
      @(negedge clk);
    end
    en = 1'b0;
    drive(1'b0, 3);
    chk("t2_busy_idle", busy, 0);

    // stuck high -> saturation
    en = 1'b1;
    drive(1'b0, 3);
    push_ovf(6, 16);
    drive(1'b1, 300);
    chk("t3_busy_after_ovf", busy, 0);
    chk("t3_duty_hold", duty, 6);
    chk("t3_period_hold", period, 16);
    drive(1'b0, 5);

    // reset in the middle of a high phase
    drive(1'b1, 4);
    drive(1'b0, 8);
    push_valid(4, 12);
    drive(1'b1, 8);
    chk("t4_busy_pre_rst", busy, 1);
    rst    = 1'b1;
    pwm_in = 1'b0;
    #1;
    chk("t4_rst_duty", duty, 0);
    chk("t4_rst_period", period, 0);
    chk("t4_rst_valid", valid, 0);
    chk("t4_rst_ovf", ovf, 0);
    chk("t4_rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4);
    drive(1'b1, 3);
    drive(1'b0, 6);
    push_valid(3, 9);
    drive(1'b1, 3);
    drive(1'b0, 6);

    // EN dropped for 20 cycles mid-stream
    push_valid(3, 9);
    drive(1'b1, 3);
    drive(1'b0, 6);
    push_valid(3, 9);
    drive(1'b1, 6);
    en = 1'b0;
    drive(1'b0, 6);
    chk("t5_busy_en0", busy, 0);
    chk("t5_duty_hold", duty, 3);
    chk("t5_period_hold", period, 9);
    drive(1'b1, 3);
    drive(1'b0, 6);
    drive(1'b1, 3);
    drive(1'b0, 2);
    en = 1'b1;
    drive(1'b0, 4);
    drive(1'b1, 7);
    drive(1'b0, 5);
    push_valid(7, 12);
    drive(1'b1, 7);
    drive(1'b0, 5);

    // 1-cycle glitch inside a low phase
    en = 1'b0;
    drive(1'b0, 2);
    en = 1'b1;
    drive(1'b0, 3);
    drive(1'b1, 4);
    drive(1'b0, 10);
    push_valid(4, 14);
    drive(1'b1, 4);
    drive(1'b0, 4);
`ifndef PWM_CAP_FILTER_EN
    push_valid(4, 8);
`endif
    drive(1'b1, 1);
    drive(1'b0, 5);
`ifdef PWM_CAP_FILTER_EN
    push_valid(4, 14);
`else
    push_valid(1, 6);
`endif
    drive(1'b1, 4);
    drive(1'b0, 10);
    push_valid(4, 14);
    drive(1'b1, 4);
    drive(1'b0, 8);
    chk("t6_duty_final", duty, 4);
    chk("t6_period_final", period, 14);
    en = 1'b0;
    drive(1'b0, 4);

    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
